// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port other than 'last' wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded lock bursts sharing one single-port dmem
// between the core (port 0) and loader/debug (port 1); read data returns one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int n         = 32,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int CW        = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic         lock0,
  input  logic         lock1,
  input  logic [n-1:0] addr0,
  input  logic [n-1:0] addr1,
  input  logic [n-1:0] wdata0,
  input  logic [n-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [n-1:0] rdata0,
  output logic [n-1:0] rdata1,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  output logic         busy
);

  localparam logic [CW:0] BMAX = (CW+1)'(BURST_MAX);

  owner_t        owner, owner_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic [CW:0]   cnt_inc;
  logic          pick0, pick1;
  logic          lock_g;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt0 (pick0),
    .gnt1 (pick1)
  );

  // A held lock overrides round-robin; dropping the request releases it in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (owner == OWN_P0 && req0) begin
        gnt0 = 1'b1;
      end else if (owner == OWN_P1 && req1) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = pick0;
        gnt1 = pick1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign cnt_inc = {1'b0, burst_cnt} + {{CW{1'b0}}, 1'b1};
  assign lock_g  = gnt0 ? lock0 : lock1;

  always_comb begin
    owner_nxt     = OWN_NONE;
    burst_cnt_nxt = '0;
    last_nxt      = last;
    if (gnt0 || gnt1) begin
      last_nxt = gnt0 ? PORT_CORE : PORT_LOAD;
      if (lock_g && (cnt_inc < BMAX)) begin
        owner_nxt     = gnt0 ? OWN_P0 : OWN_P1;
        burst_cnt_nxt = cnt_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= OWN_NONE;
      last      <= PORT_LOAD;
      burst_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end

  assign busy = (owner != OWN_NONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle comparison against a port-level model plus literal checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  dmem_arbiter #(.n(32), .BURST_MAX(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural dmem driven by the DUT: word index addr[10:5], combinational read.
  logic [31:0] dmem [0:63];
  initial for (int i = 0; i < 64; i++) dmem[i] = '0;
  always @(posedge clk) if (mem_we) dmem[mem_addr[10:5]] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr[10:5]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Port-level model: owner -1/0/1, last port, burst length, its own memory shadow.
  int          m_own = -1, m_last = 1, m_cnt = 0;
  logic        m_rv [2] = '{0, 0};
  logic [31:0] m_rd [2] = '{0, 0};
  logic [31:0] m_mem [0:63];
  initial for (int i = 0; i < 64; i++) m_mem[i] = '0;

  always @(negedge clk) begin
    logic        r [2], w [2], l [2];
    logic [31:0] a [2], d [2];
    int          g;
    r = '{req0, req1}; w = '{we0, we1}; l = '{lock0, lock1};
    a = '{addr0, addr1}; d = '{wdata0, wdata1};
    if (reset) begin
      m_own = -1; m_last = 1; m_cnt = 0;
      m_rv = '{0, 0}; m_rd = '{0, 0};
      g = -1;
    end else if (m_own >= 0 && r[m_own]) g = m_own;
    else if (r[0] && r[1]) g = (m_last == 0) ? 1 : 0;
    else if (r[0]) g = 0;
    else if (r[1]) g = 1;
    else g = -1;

    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("mem_we", 32'(mem_we), 32'(g >= 0 && w[g]));
    chk("mem_addr", mem_addr, (g >= 0) ? a[g] : 32'h0);
    chk("mem_wdata", mem_wdata, (g >= 0) ? d[g] : 32'h0);
    chk("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
    chk("busy", 32'(busy), 32'(m_own >= 0));

    if (!reset) begin
      m_rv = '{0, 0};
      if (g >= 0) begin
        m_last = g;
        if (w[g]) m_mem[a[g][10:5]] = d[g];
        else begin
          m_rv[g] = 1'b1;
          m_rd[g] = m_mem[a[g][10:5]];
        end
        if (l[g] && m_cnt + 1 < 4) begin
          m_own = g; m_cnt = m_cnt + 1;
        end else begin
          m_own = -1; m_cnt = 0;
        end
      end else begin
        m_own = -1; m_cnt = 0;
      end
    end
  end

  // Values sampled mid-cycle by apply() for the literal checks.
  int          s_g;
  logic        s_we, s_rv0, s_rv1;
  logic [31:0] s_rd0, s_rd1, s_mr;

  task automatic set0(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic apply();
    @(negedge clk);
    s_g   = gnt0 ? 0 : (gnt1 ? 1 : 2);
    s_we  = mem_we; s_rv0 = rvalid0; s_rv1 = rvalid1;
    s_rd0 = rdata0; s_rd1 = rdata1; s_mr = mem_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_g [6];
    apply();
    apply();
    reset = 1'b0;

    // Tie from reset: alternating 0,1,0,1 with rvalid one cycle behind.
    exp_g = '{0, 1, 0, 1, 0, 0};
    set0(1, 0, 0, 32'h0, 0);
    set1(1, 0, 0, 32'h20, 0);
    for (int i = 0; i < 4; i++) begin
      apply();
      chk("tie_gnt", 32'(s_g), 32'(exp_g[i]));
      if (i > 0) chk("tie_rvalid", 32'(exp_g[i-1] == 0 ? s_rv0 : s_rv1), 32'h1);
    end

    // Single read: load DEADBEEF through port 1, read it through port 0.
    idle(); set1(1, 1, 0, 32'h40, 32'hDEADBEEF);
    apply();
    chk("load_gnt", 32'(s_g), 32'd1);
    idle(); set0(1, 0, 0, 32'h40, 0);
    apply();
    chk("rd_gnt0", 32'(s_g), 32'd0);
    idle();
    apply();
    chk("rd_rvalid0", 32'(s_rv0), 32'h1);
    chk("rd_rdata0", s_rd0, 32'hDEADBEEF);

    // Write conflict at 0x20 with last=0: port 1 first, then port 0.
    set0(1, 1, 0, 32'h20, 32'h11);
    set1(1, 1, 0, 32'h20, 32'h22);
    apply();
    chk("wc_gnt", 32'(s_g), 32'd1);
    set1(0, 0, 0, 0, 0);
    apply();
    chk("wc_gnt_next", 32'(s_g), 32'd0);
    chk("wc_read22", s_mr, 32'h22);
    idle(); set1(1, 0, 0, 32'h20, 0);
    apply();
    idle();
    apply();
    chk("wc_read11", s_rd1, 32'h11);

    // Burst cap: port 0 locked for four grants, then port 1, then port 0.
    exp_g = '{0, 0, 0, 0, 1, 0};
    set0(1, 0, 1, 32'h40, 0);
    set1(1, 0, 0, 32'h20, 0);
    for (int i = 0; i < 6; i++) begin
      apply();
      chk("burst_gnt", 32'(s_g), 32'(exp_g[i]));
    end

    // Reset while port 0 owns the lock and writes.
    set0(1, 1, 1, 32'h60, 32'h55);
    reset = 1'b1;
    apply();
    chk("rst_gnt", 32'(s_g), 32'd2);
    chk("rst_we", 32'(s_we), 32'h0);
    chk("rst_rvalid0", 32'(s_rv0), 32'h0);
    apply();
    reset = 1'b0;
    set0(1, 0, 0, 32'h40, 0);
    set1(1, 0, 0, 32'h20, 0);
    apply();
    chk("rst_tie", 32'(s_g), 32'd0);
    chk("rst_nowrite", dmem[3], 32'h0);

    // Lock release: req0 drops after two locked grants, pending req1 wins at once.
    idle(); set0(1, 0, 1, 32'h40, 0);
    apply();
    chk("lr_g1", 32'(s_g), 32'd0);
    set1(1, 0, 0, 32'h20, 0);
    apply();
    chk("lr_g2", 32'(s_g), 32'd0);
    set0(0, 0, 0, 0, 0);
    apply();
    chk("lr_release", 32'(s_g), 32'd1);
    idle();
    apply();
    apply();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
